// File: rtl/hazard_sched.sv
// Hazard controller: forwarding selects, load-use stall, branch flush, and mul/div start/done sequencing.
// Zero-cycle combinational outputs from state+inputs; multi-cycle ops hold IF/ID/EX and bubble MEM until done or timeout.
module hazard_sched #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rs1_d,
    input  logic [4:0]       i_rs2_d,
    input  logic [4:0]       i_rs1_e,
    input  logic [4:0]       i_rs2_e,
    input  logic [4:0]       i_rd_e,
    input  logic [4:0]       i_rd_m,
    input  logic [4:0]       i_rd_w,
    input  logic             i_reg_write_m,
    input  logic             i_reg_write_w,
    input  logic             i_load_e,
    input  logic             i_pc_src_e,
    input  logic             i_multi_cycle_e,
    input  logic             i_ex_done_e,
    output logic [1:0]       o_forward_a_e,
    output logic [1:0]       o_forward_b_e,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_stall_e,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_flush_m,
    output logic             o_ex_start_e,
    output logic             o_mc_timeout_err,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);
    localparam int WCNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MC_TIMEOUT - 1);

    typedef enum logic {S_RUN, S_MC_WAIT} state_t;

    state_t             r_state;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic w_lw_stall;
    logic w_in_wait;
    logic w_timeout;
    logic w_release;
    logic w_br_flush;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic wr_m, input logic [4:0] rd_w,
                                           input logic wr_w);
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign o_forward_a_e = i_reset ? fwd_sel(i_rs1_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w) : 2'b00;
    assign o_forward_b_e = i_reset ? fwd_sel(i_rs2_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w) : 2'b00;

    assign w_lw_stall = i_load_e && (i_rd_e != 5'd0) && (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d);
    assign w_in_wait  = (r_state == S_MC_WAIT);
    // A stuck unit is released exactly as if it had signalled done.
    assign w_timeout  = w_in_wait && !i_ex_done_e && (r_wait_cnt == WCNT_LAST);
    assign w_release  = w_in_wait && (i_ex_done_e || w_timeout);
    assign w_br_flush = i_reset && !w_in_wait && i_pc_src_e;

    always_comb begin
        o_stall_f    = 1'b0;
        o_stall_d    = 1'b0;
        o_stall_e    = 1'b0;
        o_flush_d    = 1'b0;
        o_flush_e    = 1'b0;
        o_flush_m    = 1'b0;
        o_ex_start_e = 1'b0;
        if (i_reset) begin
            if (w_in_wait) begin
                if (!w_release) begin
                    o_stall_f = 1'b1;
                    o_stall_d = 1'b1;
                    o_stall_e = 1'b1;
                    o_flush_m = 1'b1;
                end
            end else if (i_pc_src_e) begin
                o_flush_d = 1'b1;
                o_flush_e = 1'b1;
            end else if (i_multi_cycle_e) begin
                o_ex_start_e = 1'b1;
                o_stall_f    = 1'b1;
                o_stall_d    = 1'b1;
                o_stall_e    = 1'b1;
                o_flush_m    = 1'b1;
            end else if (w_lw_stall) begin
                o_stall_f = 1'b1;
                o_stall_d = 1'b1;
                o_flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!i_pc_src_e && i_multi_cycle_e) begin
                        r_state    <= S_MC_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_MC_WAIT: begin
                    if (w_release)
                        r_state <= S_RUN;
                    else
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_timeout)
                        r_timeout_err <= 1'b1;
                end
                default: r_state <= S_RUN;
            endcase
            if (o_stall_f && r_stall_cnt != {CNT_W{1'b1}})
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_br_flush && r_flush_cnt != {CNT_W{1'b1}})
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_mc_timeout_err = r_timeout_err;
    assign o_stall_count    = r_stall_cnt;
    assign o_flush_count    = r_flush_cnt;
endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: vector table for combinational hazards, hand sequences for multi-cycle cases.
module tb_hazard_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        rwm, rww, lde, pcs, mc, done;
    logic [1:0]  fa, fb;
    logic        sf, sd, se, fd, fe, fm, st, err;
    logic [31:0] scnt, fcnt;
    logic [10:0] outs;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [10:0] E_NONE = 11'h000;
    localparam logic [10:0] E_LW   = 11'h064;
    localparam logic [10:0] E_BR   = 11'h00C;
    localparam logic [10:0] E_MC   = 11'h073;
    localparam logic [10:0] E_MCW  = 11'h072;
    localparam logic [10:0] FA_M   = 11'h400;
    localparam logic [10:0] FA_W   = 11'h200;
    localparam logic [10:0] FB_M   = 11'h100;
    localparam logic [10:0] FB_W   = 11'h080;

    hazard_sched #(.MC_TIMEOUT(8), .CNT_W(32)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_rs1_d(rs1d), .i_rs2_d(rs2d), .i_rs1_e(rs1e), .i_rs2_e(rs2e),
        .i_rd_e(rde), .i_rd_m(rdm), .i_rd_w(rdw),
        .i_reg_write_m(rwm), .i_reg_write_w(rww),
        .i_load_e(lde), .i_pc_src_e(pcs), .i_multi_cycle_e(mc), .i_ex_done_e(done),
        .o_forward_a_e(fa), .o_forward_b_e(fb),
        .o_stall_f(sf), .o_stall_d(sd), .o_stall_e(se),
        .o_flush_d(fd), .o_flush_e(fe), .o_flush_m(fm),
        .o_ex_start_e(st), .o_mc_timeout_err(err),
        .o_stall_count(scnt), .o_flush_count(fcnt)
    );

    always #5 clk = ~clk;
    assign outs = {fa, fb, sf, sd, se, fd, fe, fm, st};

    typedef struct {
        string       name;
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic        rwm, rww, lde, pcs, done;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mkv(string n, logic [4:0] a1d, logic [4:0] a2d, logic [4:0] a1e,
                                 logic [4:0] a2e, logic [4:0] ade, logic [4:0] adm, logic [4:0] adw,
                                 logic wm, logic ww, logic ld, logic br, logic dn, logic [10:0] e);
        vec_t v;
        v.name = n; v.rs1d = a1d; v.rs2d = a2d; v.rs1e = a1e; v.rs2e = a2e;
        v.rde = ade; v.rdm = adm; v.rdw = adw; v.rwm = wm; v.rww = ww;
        v.lde = ld; v.pcs = br; v.done = dn; v.exp = e;
        return v;
    endfunction

    task automatic idle();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        rwm = 0; rww = 0; lde = 0; pcs = 0; mc = 0; done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //                name         rs1d rs2d rs1e rs2e rde rdm rdw rwm rww lde pcs dn  expected
        tbl[0]  = mkv("idle",          0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  0, E_NONE);
        tbl[1]  = mkv("fwd_mem_prio",  0,   0,   5,   0,   0,  5,  5,  1,  1,  0,  0,  0, FA_M);
        tbl[2]  = mkv("fwd_wb",        0,   0,   5,   0,   0,  5,  5,  0,  1,  0,  0,  0, FA_W);
        tbl[3]  = mkv("fwd_x0",        0,   0,   0,   0,   0,  0,  0,  1,  1,  0,  0,  0, E_NONE);
        tbl[4]  = mkv("fwd_both_mem",  0,   0,   7,   7,   0,  7,  7,  1,  1,  0,  0,  0, FA_M | FB_M);
        tbl[5]  = mkv("fwd_mixed",     0,   0,   9,   4,   0,  4,  9,  1,  1,  0,  0,  0, FA_W | FB_M);
        tbl[6]  = mkv("fwd_b_wb",      0,   0,   0,  12,   0, 12, 12,  0,  1,  0,  0,  0, FB_W);
        tbl[7]  = mkv("lw_rs2",        0,   3,   0,   0,   3,  0,  0,  0,  0,  1,  0,  0, E_LW);
        tbl[8]  = mkv("lw_rd0",        0,   0,   0,   0,   0,  0,  0,  0,  0,  1,  0,  0, E_NONE);
        tbl[9]  = mkv("lw_rs1",        3,   0,   0,   0,   3,  0,  0,  0,  0,  1,  0,  0, E_LW);
        tbl[10] = mkv("no_load",       3,   0,   0,   0,   3,  0,  0,  0,  0,  0,  0,  0, E_NONE);
        tbl[11] = mkv("br_over_lw",    3,   0,   0,   0,   3,  0,  0,  0,  0,  1,  1,  0, E_BR);
        tbl[12] = mkv("br_fwd",        0,   0,   6,   0,   0,  6,  0,  1,  0,  0,  1,  0, E_BR | FA_M);
        tbl[13] = mkv("done_in_run",   0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  1, E_NONE);

        // Reset with every hazard input active: outputs forced low.
        idle();
        reset = 0;
        rs1e = 5; rdm = 5; rwm = 1; lde = 1; rde = 3; rs1d = 3; pcs = 1; mc = 1;
        #2 chk("rst_outs", 32'(outs), 32'(E_NONE));
        tick();
        chk("rst_stall_cnt", scnt, 0);
        chk("rst_flush_cnt", fcnt, 0);
        chk("rst_err", 32'(err), 0);
        idle();
        reset = 1;
        tick();

        // Load-use: one bubble, StallCount 0 -> 1.
        lde = 1; rde = 3; rs2d = 3;
        #2 chk("lu_outs", 32'(outs), 32'(E_LW));
        chk("lu_cnt_before", scnt, 0);
        tick();
        idle();
        #2 chk("lu_after", 32'(outs), 32'(E_NONE));
        chk("lu_cnt_after", scnt, 1);

        // Branch beats load-use.
        pcs = 1; lde = 1; rde = 3; rs1d = 3;
        #2 chk("br_outs", 32'(outs), 32'(E_BR));
        tick();
        idle();
        #2 chk("br_flush_cnt", fcnt, 1);
        chk("br_stall_cnt", scnt, 1);

        for (int i = 0; i < 14; i++) begin
            rs1d = tbl[i].rs1d; rs2d = tbl[i].rs2d; rs1e = tbl[i].rs1e; rs2e = tbl[i].rs2e;
            rde = tbl[i].rde; rdm = tbl[i].rdm; rdw = tbl[i].rdw;
            rwm = tbl[i].rwm; rww = tbl[i].rww; lde = tbl[i].lde; pcs = tbl[i].pcs;
            done = tbl[i].done; mc = 0;
            #2 chk(tbl[i].name, 32'(outs), 32'(tbl[i].exp));
            tick();
        end
        idle();
        #2 chk("tbl_stall_cnt", scnt, 3);
        chk("tbl_flush_cnt", fcnt, 3);

        // Multi-cycle op, done 4 cycles after start; branch during wait is ignored.
        mc = 1;
        #2 chk("mc_start", 32'(outs), 32'(E_MC));
        tick();
        for (int i = 1; i <= 3; i++) begin
            pcs = (i == 2); lde = (i == 2); rde = 3; rs1d = 3;
            #2 chk($sformatf("mc_wait%0d", i), 32'(outs), 32'(E_MCW));
            tick();
        end
        pcs = 0; lde = 0; done = 1;
        #2 chk("mc_done", 32'(outs), 32'(E_NONE));
        tick();
        idle();
        #2 chk("mc_back_run", 32'(outs), 32'(E_NONE));
        chk("mc_stall_cnt", scnt, 7);
        chk("mc_flush_cnt", fcnt, 3);

        // Timeout: unit never answers.
        mc = 1;
        #2 chk("to_start", 32'(outs), 32'(E_MC));
        tick();
        for (int i = 1; i <= 7; i++) begin
            #2 chk($sformatf("to_wait%0d", i), 32'(outs), 32'(E_MCW));
            tick();
        end
        #2 chk("to_release", 32'(outs), 32'(E_NONE));
        chk("to_err_before", 32'(err), 0);
        tick();
        mc = 0;
        #2 chk("to_err_set", 32'(err), 1);
        chk("to_run", 32'(outs), 32'(E_NONE));
        for (int i = 0; i < 3; i++) tick();
        chk("to_err_sticky", 32'(err), 1);
        chk("to_stall_cnt", scnt, 15);

        // Reset in the middle of MC_WAIT.
        mc = 1;
        tick();
        tick();
        reset = 0;
        rs1e = 5; rdm = 5; rwm = 1;
        #2 chk("rstw_outs", 32'(outs), 32'(E_NONE));
        tick();
        chk("rstw_err", 32'(err), 0);
        chk("rstw_stall_cnt", scnt, 0);
        chk("rstw_flush_cnt", fcnt, 0);
        reset = 1;
        mc = 0;
        #2 chk("rstw_run", 32'(outs), 32'(FA_M));
        tick();
        chk("rstw_no_stall", scnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
